// File: rtl/timer_apb_regs.sv
// -----------------------------------------------------------------------------
// timer_apb_regs
//   APB slave register block that sits directly in front of the timer counter
//   stage. It holds TDR (reload value) and TCR (control), reads back the live
//   count, captures overflow/underflow rising edges into W1C status bits, and
//   raises a maskable, registered interrupt.
//
//   Register map (index = paddr):
//     0 TDR  RW  full width
//     1 TCR  RW  bits 7,5,4,1,0 (load_tdr, up_down, enable, cks[1:0])
//     2 TSR  W1C bit1=UDF, bit0=OVF
//     3 TCNT RO  live cnt
//     4 TIER RW  bit1=UDFIE, bit0=OVFIE
//     5..  unmapped -> pslverr
//
// Ports
//   pclk, presetn          APB clock, async active-low reset
//   psel, penable, pwrite  APB control
//   paddr, pwdata          register index, write data
//   prdata, pready,        read data / completion / error; prdata and
//   pslverr                pslverr are only non-zero while pready=1
//   cnt                    live count from the counter stage
//   s_ovf, s_udf           sticky overflow/underflow levels from the counter
//   tdr_reg                TDR value to the counter
//   enable, up_down,       TCR[4], TCR[5], TCR[7]
//   load_tdr
//   cks                    TCR[1:0] clock select to the prescaler
//   irq                    |(TSR & TIER), registered
// -----------------------------------------------------------------------------
module timer_apb_regs #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   input  logic [DATA_WIDTH-1:0] cnt,
   input  logic                  s_ovf,
   input  logic                  s_udf,
   output logic [DATA_WIDTH-1:0] tdr_reg,
   output logic                  enable,
   output logic                  up_down,
   output logic                  load_tdr,
   output logic [1:0]            cks,
   output logic                  irq
);

   localparam logic [3:0]            WAIT_LAST = 4'(WAIT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] IDX_TDR   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] IDX_TCR   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] IDX_TSR   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] IDX_TCNT  = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] IDX_TIER  = ADDR_WIDTH'(4);
   localparam logic [7:0]            TCR_MASK  = 8'hB3;

   // The state register records the bus phase seen in the previous cycle:
   // SETUP means a setup phase has been accepted, so the current cycle is the
   // first access cycle; ACCESS means we are inserting wait states. This lets
   // WAIT_CYCLES=0 complete in the very first access cycle.
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t     state, state_nxt;
   logic [3:0] wcnt, wcnt_nxt;

   logic                  acc_phase;
   logic                  xfer_done;
   logic                  err_cond;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_mux;

   logic [DATA_WIDTH-1:0] tdr_q;
   logic [7:0]            tcr_q;
   logic [1:0]            tsr_q, tsr_nxt;
   logic [1:0]            tier_q;
   logic                  ovf_d, udf_d;
   logic                  ovf_rise, udf_rise;
   logic [1:0]            w1c;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      case (state)
         IDLE: begin
            wcnt_nxt = '0;
            if (psel && !penable) state_nxt = SETUP;
         end
         SETUP, ACCESS: begin
            if (!psel) begin
               // master abandoned the transfer: nothing commits
               state_nxt = IDLE;
               wcnt_nxt  = '0;
            end else if (penable) begin
               if (wcnt == WAIT_LAST) begin
                  state_nxt = IDLE;
                  wcnt_nxt  = '0;
               end else begin
                  state_nxt = ACCESS;
                  wcnt_nxt  = wcnt + 4'd1;
               end
            end else begin
               // a fresh setup phase restarts the transfer
               state_nxt = SETUP;
               wcnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      acc_phase = psel && penable && (state != IDLE);
      xfer_done = acc_phase && (wcnt == WAIT_LAST);
      err_cond  = (paddr > IDX_TIER) || (pwrite && (paddr == IDX_TCNT));
      pready    = xfer_done;
      pslverr   = xfer_done && err_cond;
      prdata    = (xfer_done && !err_cond && !pwrite) ? rd_mux : '0;
   end

   // ---------------------------------------------------------- read mux
   always_comb begin
      rd_mux = '0;
      case (paddr)
         IDX_TDR:  rd_mux = tdr_q;
         IDX_TCR:  rd_mux = DATA_WIDTH'(tcr_q);
         IDX_TSR:  rd_mux = DATA_WIDTH'(tsr_q);
         IDX_TCNT: rd_mux = cnt;
         IDX_TIER: rd_mux = DATA_WIDTH'(tier_q);
         default:  rd_mux = '0;
      endcase
   end

   // ------------------------------------------------------- registers
   assign wr_en = xfer_done && pwrite && !err_cond;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tdr_q  <= '0;
         tcr_q  <= '0;
         tier_q <= '0;
      end else if (wr_en) begin
         case (paddr)
            IDX_TDR:  tdr_q  <= pwdata;
            IDX_TCR:  tcr_q  <= pwdata[7:0] & TCR_MASK;
            IDX_TIER: tier_q <= pwdata[1:0];
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------- status / irq
   // s_ovf/s_udf are sticky levels, so only a 0->1 transition is an event;
   // otherwise a W1C would be undone on the next cycle.
   assign ovf_rise = s_ovf && !ovf_d;
   assign udf_rise = s_udf && !udf_d;
   assign w1c      = (wr_en && (paddr == IDX_TSR)) ? pwdata[1:0] : 2'b00;

   // set dominates clear when both land in the same cycle
   always_comb begin
      tsr_nxt    = tsr_q & ~w1c;
      tsr_nxt[0] = tsr_nxt[0] | ovf_rise;
      tsr_nxt[1] = tsr_nxt[1] | udf_rise;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ovf_d <= 1'b0;
         udf_d <= 1'b0;
         tsr_q <= '0;
         irq   <= 1'b0;
      end else begin
         ovf_d <= s_ovf;
         udf_d <= s_udf;
         tsr_q <= tsr_nxt;
         irq   <= |(tsr_q & tier_q);
      end
   end

   // ---------------------------------------------------------- outputs
   assign tdr_reg  = tdr_q;
   assign enable   = tcr_q[4];
   assign up_down  = tcr_q[5];
   assign load_tdr = tcr_q[7];
   assign cks      = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_regs
//   Directed bench for timer_apb_regs. Two instances share the bus except for
//   psel: u_dut0 has no wait states, u_dut3 has WAIT_CYCLES=3.
// -----------------------------------------------------------------------------
module tb_timer_apb_regs;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       psel0, psel3, penable, pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata, cnt;
   logic       s_ovf, s_udf;

   logic [7:0] prdata0, prdata3, tdr0, tdr3;
   logic       pready0, pready3, pslverr0, pslverr3;
   logic       en0, en3, ud0, ud3, ld0, ld3, irq0, irq3;
   logic [1:0] cks0, cks3;

   int errs   = 0;
   int checks = 0;

   logic [7:0] rdv;
   logic       erv;
   int         nac;
   logic [7:0] tdr0_at_done;

   always #5 pclk = ~pclk;

   timer_apb_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
      .pready(pready0), .pslverr(pslverr0), .cnt(cnt), .s_ovf(s_ovf),
      .s_udf(s_udf), .tdr_reg(tdr0), .enable(en0), .up_down(ud0),
      .load_tdr(ld0), .cks(cks0), .irq(irq0)
   );

   timer_apb_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_CYCLES(3)) u_dut3 (
      .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
      .pready(pready3), .pslverr(pslverr3), .cnt(cnt), .s_ovf(s_ovf),
      .s_udf(s_udf), .tdr_reg(tdr3), .enable(en3), .up_down(ud3),
      .load_tdr(ld3), .cks(cks3), .irq(irq3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One APB transfer to the selected instance. nacc = number of access
   // cycles up to and including the one with pready. If udf_at_done is set,
   // s_udf rises in the completing cycle so it lands on the commit edge.
   task automatic apb(input int which, input logic wr, input logic [2:0] a,
                      input logic [7:0] wd, input logic udf_at_done,
                      output logic [7:0] rd, output logic err, output int nacc);
      logic rdy;
      bit   done;
      done = 0;
      rd   = '0;
      err  = 1'b0;
      nacc = 0;
      @(negedge pclk);
      if (which == 3) psel3 = 1'b1; else psel0 = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      @(negedge pclk);
      penable = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         rdy  = (which == 3) ? pready3 : pready0;
         nacc = i + 1;
         if (rdy) begin
            done         = 1;
            rd           = (which == 3) ? prdata3 : prdata0;
            err          = (which == 3) ? pslverr3 : pslverr0;
            tdr0_at_done = tdr0;
            if (udf_at_done) s_udf = 1'b1;
         end else begin
            @(negedge pclk);
         end
      end
      if (!done) chk("pready_timeout", 32'd0, 32'd1);
      @(negedge pclk);
      psel0   = 1'b0;
      psel3   = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      presetn = 1'b0;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; cnt = '0; s_ovf = 1'b0; s_udf = 1'b0;
      tdr0_at_done = '0;

      // 1: reset state
      #22;
      chk("rst_tdr0",   tdr0,  8'h00);
      chk("rst_ctrl0",  {en0, ud0, ld0, cks0, irq0}, 6'b0);
      chk("rst_bus0",   {prdata0, pready0, pslverr0}, 10'b0);
      chk("rst_ctrl3",  {tdr3, en3, ud3, ld3, cks3, irq3}, 14'b0);
      @(negedge pclk);
      presetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         apb(0, 1'b0, 3'(i), 8'h00, 1'b0, rdv, erv, nac);
         chk($sformatf("rst_read%0d", i), {rdv, erv}, 9'h000);
      end

      // 2: no-wait write of TDR
      apb(0, 1'b1, 3'd0, 8'hA5, 1'b0, rdv, erv, nac);
      chk("tdr_nacc",      nac, 1);
      chk("tdr_err",       erv, 1'b0);
      chk("tdr_before",    tdr0_at_done, 8'h00);
      chk("tdr_after",     tdr0, 8'hA5);
      apb(0, 1'b0, 3'd0, 8'h00, 1'b0, rdv, erv, nac);
      chk("tdr_readback",  rdv, 8'hA5);

      // 3: three wait states, TCR write with reserved bits
      apb(3, 1'b1, 3'd1, 8'hFF, 1'b0, rdv, erv, nac);
      chk("tcr_nacc",      nac, 4);
      chk("tcr_outputs",   {en3, ud3, ld3, cks3}, 5'b11111);
      apb(3, 1'b0, 3'd1, 8'h00, 1'b0, rdv, erv, nac);
      chk("tcr_readback",  rdv, 8'hB3);
      chk("tcr_rd_nacc",   nac, 4);

      // 4: error responses
      apb(0, 1'b1, 3'd6, 8'h5C, 1'b0, rdv, erv, nac);
      chk("err_wr6",       erv, 1'b1);
      apb(0, 1'b1, 3'd3, 8'h12, 1'b0, rdv, erv, nac);
      chk("err_wr_tcnt",   erv, 1'b1);
      apb(0, 1'b0, 3'd0, 8'h00, 1'b0, rdv, erv, nac);
      chk("err_tdr_kept",  rdv, 8'hA5);
      apb(0, 1'b0, 3'd1, 8'h00, 1'b0, rdv, erv, nac);
      chk("err_tcr_kept",  rdv, 8'h00);
      apb(0, 1'b0, 3'd7, 8'h00, 1'b0, rdv, erv, nac);
      chk("err_rd7",       {rdv, erv}, 9'h001);
      cnt = 8'h5A;
      apb(0, 1'b0, 3'd3, 8'h00, 1'b0, rdv, erv, nac);
      chk("tcnt_read",     {rdv, erv}, {8'h5A, 1'b0});

      // 5: status capture, W1C, interrupt
      apb(0, 1'b1, 3'd4, 8'h01, 1'b0, rdv, erv, nac);
      @(negedge pclk);
      s_ovf = 1'b1;
      @(negedge pclk); #1;
      chk("irq_lag",       irq0, 1'b0);
      @(negedge pclk); #1;
      chk("irq_set",       irq0, 1'b1);
      chk("irq3_masked",   irq3, 1'b0);
      apb(0, 1'b0, 3'd2, 8'h00, 1'b0, rdv, erv, nac);
      chk("tsr_ovf",       rdv, 8'h01);
      apb(0, 1'b1, 3'd2, 8'h01, 1'b0, rdv, erv, nac);
      apb(0, 1'b0, 3'd2, 8'h00, 1'b0, rdv, erv, nac);
      chk("tsr_cleared",   rdv, 8'h00);
      chk("irq_cleared",   irq0, 1'b0);
      apb(0, 1'b1, 3'd2, 8'h02, 1'b1, rdv, erv, nac);
      apb(0, 1'b0, 3'd2, 8'h00, 1'b0, rdv, erv, nac);
      chk("tsr_set_wins",  rdv, 8'h02);
      chk("irq_udf_mask",  irq0, 1'b0);
      apb(0, 1'b1, 3'd4, 8'hFF, 1'b0, rdv, erv, nac);
      @(negedge pclk); #1;
      chk("irq_udf_en",    irq0, 1'b1);
      apb(0, 1'b0, 3'd4, 8'h00, 1'b0, rdv, erv, nac);
      chk("tier_readback", rdv, 8'h03);

      // 6: reset during the access phase of a TDR write
      @(negedge pclk);
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h3C;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      chk("abort_in_access", pready0, 1'b1);
      #1;
      presetn = 1'b0;
      #1;
      chk("abort_pready",  pready0, 1'b0);
      @(negedge pclk);
      psel0 = 1'b0; penable = 1'b0;
      chk("abort_tdr",     tdr0, 8'h00);
      chk("abort_ctrl3",   {en3, ud3, ld3, cks3, irq0}, 6'b0);
      @(negedge pclk);
      presetn = 1'b1;
      s_ovf = 1'b0; s_udf = 1'b0;
      apb(0, 1'b1, 3'd0, 8'h77, 1'b0, rdv, erv, nac);
      chk("post_rst_nacc", nac, 1);
      chk("post_rst_tdr",  tdr0, 8'h77);
      apb(0, 1'b0, 3'd0, 8'h00, 1'b0, rdv, erv, nac);
      chk("post_rst_read", rdv, 8'h77);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
